// File: rtl/bos_spi_slave.sv
// bos_spi_slave
//
// SPI slave (CPOL=1, CPHA=0) in front of a 2^ADDR_W x 16-bit register file.
// A frame is 24 bits, MSB first: R/W (1 = read), 7-bit address, 16-bit data.
// Every SPI pin is oversampled by the system clock, so sck must run at
// least SCK_DIV_MIN times slower than clk.
//
// Optional feature macro: BOS_SPI_SLAVE_ABORT_CNT_EN
//   defined   : abort_cnt counts aborted frames and saturates at 8'hFF
//   undefined : abort_cnt is tied to 8'h00 and no counter is built
//
// Ports
//   clk, rst   system clock, asynchronous active-high reset
//   sl         SPI chip select, active-low
//   sck        SPI clock, idles high
//   sdio_i     sampled value of the bidirectional data pin
//   sdio_o     data driven on the pin during the read phase
//   sdio_oe    pin drive enable (tristate buffer lives outside this block)
//   loc_addr   local read address
//   loc_data   local read data, one clk latency
//   wr_stb     one-clk pulse per committed SPI write
//   wr_addr    address of the last committed write
//   wr_data    data of the last committed write
//   abort_cnt  number of aborted frames (see macro above)

`timescale 1ns/1ps

module bos_spi_slave #(
    parameter int ADDR_W      = 4,
    parameter int SCK_DIV_MIN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sl,
    input  logic              sck,
    input  logic              sdio_i,
    output logic              sdio_o,
    output logic              sdio_oe,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [15:0]       loc_data,
    output logic              wr_stb,
    output logic [6:0]        wr_addr,
    output logic [15:0]       wr_data,
    output logic [7:0]        abort_cnt
);

    localparam int NUM_REGS = 1 << ADDR_W;

    // The read path takes 3 clk from an sck pin edge to an updated sdio_o,
    // which has to land before the master samples half an sck period later.
    if (SCK_DIV_MIN < 8) begin : g_bad_div
        $error("bos_spi_slave: SCK_DIV_MIN below 8 breaks read timing");
    end
    if (ADDR_W < 1 || ADDR_W > 7) begin : g_bad_addr_w
        $error("bos_spi_slave: ADDR_W must be between 1 and 7");
    end

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD,
        DONE
    } state_t;

    // Addresses above the implemented range are accepted on the wire but
    // never touch the register file.
    function automatic logic addr_in_range(input logic [6:0] a);
        return (a >> ADDR_W) == 7'd0;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              sl_s1_q, sl_s1_d, sl_s2_q, sl_s2_d;
    logic              sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_s3_q, sck_s3_d;
    logic              sdio_s1_q, sdio_s1_d, sdio_s2_q, sdio_s2_d;
    logic [1:0]        sync_fill_q, sync_fill_d;
    logic              armed_q, armed_d;
    state_t            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [22:0]       shift_in_q, shift_in_d;
    logic [15:0]       shift_out_q, shift_out_d;
    logic              sdio_o_q, sdio_o_d;
    logic              oe_q, oe_d;
    logic              wr_pend_q, wr_pend_d;
    logic              wr_stb_q, wr_stb_d;
    logic [6:0]        wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [15:0]       loc_data_q, loc_data_d;

    logic [15:0]       regs_q [NUM_REGS];
    logic              reg_we;
    logic [ADDR_W-1:0] reg_waddr;
    logic [15:0]       reg_wdata;

    logic              sck_fall;
    logic              sck_rise;
    logic [22:0]       shift_in_next;

    // The third sck stage exists only to turn the synchronised level into
    // edge strobes; sdio_s2 is aligned with sck_s2, so the data bit seen on
    // a falling-edge strobe was sampled together with that edge.
    assign sck_fall      = sck_s3_q & ~sck_s2_q;
    assign sck_rise      = ~sck_s3_q & sck_s2_q;
    assign shift_in_next = {shift_in_q[21:0], sdio_s2_q};

    // ------------------------------------------------------------------
    // Next-state logic for synchronisers, FSM, shifters and outputs
    // ------------------------------------------------------------------
    always_comb begin
        sl_s1_d     = sl;
        sl_s2_d     = sl_s1_q;
        sck_s1_d    = sck;
        sck_s2_d    = sck_s1_q;
        sck_s3_d    = sck_s2_q;
        sdio_s1_d   = sdio_i;
        sdio_s2_d   = sdio_s1_q;

        // sync_fill marks when sl_s2 holds a real pin sample instead of its
        // reset value; armed then requires a genuine high level on sl, so a
        // chip select already low at reset release never starts a frame.
        sync_fill_d = {sync_fill_q[0], 1'b1};
        armed_d     = armed_q | (sync_fill_q[1] & sl_s2_q);

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        sdio_o_d    = sdio_o_q;
        oe_d        = oe_q;
        wr_pend_d   = 1'b0;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we      = 1'b0;
        reg_waddr   = '0;
        reg_wdata   = '0;

        loc_data_d  = regs_q[loc_addr];

        // The strobe trails the register write by one clk; the shift
        // register still holds the committed frame at that point.
        if (wr_pend_q) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = shift_in_q[22:16];
            wr_data_d = shift_in_q[15:0];
        end

        case (state_q)
            IDLE: begin
                oe_d = 1'b0;
                if (armed_q && !sl_s2_q) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end

            CMD, WR, RD: begin
                if (sl_s2_q) begin
                    state_d  = IDLE;
                    oe_d     = 1'b0;
                    sdio_o_d = 1'b0;
                end else begin
                    if (sck_fall) begin
                        shift_in_d = shift_in_next;
                        bit_cnt_d  = bit_cnt_q + 5'd1;

                        if (state_q == CMD && bit_cnt_q == 5'd7) begin
                            if (shift_in_next[7]) begin
                                state_d = RD;
                                shift_out_d = addr_in_range(shift_in_next[6:0])
                                            ? regs_q[shift_in_next[ADDR_W-1:0]]
                                            : 16'h0000;
                            end else begin
                                state_d = WR;
                            end
                        end

                        if (state_q != CMD && bit_cnt_q == 5'd23) begin
                            state_d = DONE;
                            if (state_q == WR && addr_in_range(shift_in_next[22:16])) begin
                                reg_we    = 1'b1;
                                reg_waddr = shift_in_next[ADDR_W+15:16];
                                reg_wdata = shift_in_next[15:0];
                                wr_pend_d = 1'b1;
                            end
                        end
                    end

                    // First rising edge in RD turns the driver on with data[15].
                    if (state_q == RD && sck_rise) begin
                        oe_d        = 1'b1;
                        sdio_o_d    = shift_out_q[15];
                        shift_out_d = {shift_out_q[14:0], 1'b0};
                    end
                end
            end

            DONE: begin
                // The last read bit stays on the pin until the master's
                // closing rising edge or until chip select goes away.
                if (sck_rise || sl_s2_q) begin
                    oe_d     = 1'b0;
                    sdio_o_d = 1'b0;
                end
                if (sl_s2_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d  = IDLE;
                oe_d     = 1'b0;
                sdio_o_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_s1_q     <= 1'b1;
            sl_s2_q     <= 1'b1;
            sck_s1_q    <= 1'b1;
            sck_s2_q    <= 1'b1;
            sck_s3_q    <= 1'b1;
            sdio_s1_q   <= 1'b0;
            sdio_s2_q   <= 1'b0;
            sync_fill_q <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            sdio_o_q    <= 1'b0;
            oe_q        <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            loc_data_q  <= '0;
        end else begin
            sl_s1_q     <= sl_s1_d;
            sl_s2_q     <= sl_s2_d;
            sck_s1_q    <= sck_s1_d;
            sck_s2_q    <= sck_s2_d;
            sck_s3_q    <= sck_s3_d;
            sdio_s1_q   <= sdio_s1_d;
            sdio_s2_q   <= sdio_s2_d;
            sync_fill_q <= sync_fill_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            sdio_o_q    <= sdio_o_d;
            oe_q        <= oe_d;
            wr_pend_q   <= wr_pend_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            loc_data_q  <= loc_data_d;
        end
    end

    // Register file; loc_data samples it before a same-clk write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (reg_we) begin
            regs_q[reg_waddr] <= reg_wdata;
        end
    end

`ifdef BOS_SPI_SLAVE_ABORT_CNT_EN
    // An abort is chip select released while a frame is still in flight.
    logic       abort;
    logic [7:0] abort_cnt_q, abort_cnt_d;

    assign abort = sl_s2_q && (state_q == CMD || state_q == WR || state_q == RD);

    always_comb begin
        abort_cnt_d = abort_cnt_q;
        if (abort && abort_cnt_q != 8'hFF) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_cnt_q <= 8'h00;
        end else begin
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign abort_cnt = abort_cnt_q;
`else
    assign abort_cnt = 8'h00;
`endif

    // Chip select going high releases the pin in the same clk it is seen;
    // reset clears oe_q asynchronously.
    assign sdio_oe  = oe_q & ~sl_s2_q;
    assign sdio_o   = sdio_o_q;
    assign loc_data = loc_data_q;
    assign wr_stb   = wr_stb_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_bos_spi_slave.sv
// tb_bos_spi_slave
//
// Bench for bos_spi_slave acting as SPI master at clk/sck = 8.
// Expected writes and reads are queued when frames are driven and popped
// when the DUT strobes a write or the master finishes reading a frame.

`timescale 1ns/1ps

module tb_bos_spi_slave;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sl;
    logic              sck;
    logic              sdio_i;
    logic              sdio_o;
    logic              sdio_oe;
    logic [ADDR_W-1:0] loc_addr;
    logic [15:0]       loc_data;
    logic              wr_stb;
    logic [6:0]        wr_addr;
    logic [15:0]       wr_data;
    logic [7:0]        abort_cnt;

`ifdef BOS_SPI_SLAVE_ABORT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    bos_spi_slave #(.ADDR_W(ADDR_W), .SCK_DIV_MIN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sl        (sl),
        .sck       (sck),
        .sdio_i    (sdio_i),
        .sdio_o    (sdio_o),
        .sdio_oe   (sdio_oe),
        .loc_addr  (loc_addr),
        .loc_data  (loc_data),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .abort_cnt (abort_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard state and reference register file
    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t               exp_wr_q [$];
    logic [15:0]       exp_rd_q [$];
    logic [15:0]       model_regs [16];
    int                wr_stb_cnt = 0;
    int                checks_total = 0;
    int                checks_passed = 0;
    logic [15:0]       prev_loc = '0;
    logic [ADDR_W-1:0] prev_loc_addr = '0;
    wr_t               mon_e;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives nbits of a frame with sl already low; collects read bits
    // sampled just before each falling edge from bit 9 on, and counts
    // moments where the pin drive enable is not what the master expects.
    task automatic applyStimulus(input logic [23:0] frame, input int nbits,
                                 output logic [15:0] rdata, output int oe_bad);
        rdata  = '0;
        oe_bad = 0;
        for (int k = 1; k <= nbits; k++) begin
            sdio_i = frame[24-k];
            repeat (4) @(negedge clk);
            if (k >= 9) rdata = {rdata[14:0], sdio_o};
            if (sdio_oe !== (k >= 9 && frame[23])) oe_bad++;
            sck = 1'b0;
            repeat (4) @(negedge clk);
            sck = 1'b1;
        end
        repeat (4) @(negedge clk);
        if (nbits == 24 && sdio_oe !== 1'b0) oe_bad++;
    endtask

    task automatic doSpi(input logic [23:0] frame, output logic [15:0] rdata,
                         output int oe_bad);
        sl = 1'b0;
        applyStimulus(frame, 24, rdata, oe_bad);
        sl = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spiWrite(input logic [6:0] addr, input logic [15:0] data);
        logic [15:0] rd;
        int          ob;
        if ((addr >> ADDR_W) == 7'd0) exp_wr_q.push_back({addr, data});
        doSpi({1'b0, addr, data}, rd, ob);
        checkOutput("write frame oe quiet", ob, 0);
    endtask

    task automatic spiRead(input logic [6:0] addr);
        logic [15:0] rd;
        int          ob;
        logic [15:0] junk;
        junk = 16'($urandom);
        exp_rd_q.push_back(((addr >> ADDR_W) == 7'd0) ? model_regs[addr[ADDR_W-1:0]] : 16'h0000);
        doSpi({1'b1, addr, junk}, rd, ob);
        checkOutput("read frame oe window", ob, 0);
        checkOutput("read data", rd, exp_rd_q.pop_front());
    endtask

    // Write-strobe monitor: pops expected commits and checks the local
    // read port shows the old value in the commit clk and the new one after.
    always @(negedge clk) begin
        if (rst === 1'b0 && wr_stb === 1'b1) begin
            wr_stb_cnt++;
            if (exp_wr_q.size() == 0) begin
                checkOutput("unexpected wr_stb", 32'(wr_stb), 32'd0);
            end else begin
                mon_e = exp_wr_q.pop_front();
                checkOutput("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                checkOutput("wr_data", 32'(wr_data), 32'(mon_e.data));
                if (loc_addr == mon_e.addr[ADDR_W-1:0] && prev_loc_addr == loc_addr) begin
                    checkOutput("loc_data old in commit clk", 32'(prev_loc),
                                32'(model_regs[mon_e.addr[ADDR_W-1:0]]));
                    checkOutput("loc_data new after commit", 32'(loc_data), 32'(mon_e.data));
                end
                model_regs[mon_e.addr[ADDR_W-1:0]] = mon_e.data;
            end
        end
        prev_loc      = loc_data;
        prev_loc_addr = loc_addr;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] rd;
        int          ob;
        logic [6:0]  ra;
        logic [15:0] rdat;

        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        rst      = 1'b1;
        sl       = 1'b0;
        sck      = 1'b1;
        sdio_i   = 1'b0;
        loc_addr = '0;
        repeat (3) @(negedge clk);

        checkOutput("reset sdio_oe", 32'(sdio_oe), 0);
        checkOutput("reset sdio_o", 32'(sdio_o), 0);
        checkOutput("reset wr_stb", 32'(wr_stb), 0);
        checkOutput("reset wr_addr", 32'(wr_addr), 0);
        checkOutput("reset wr_data", 32'(wr_data), 0);
        checkOutput("reset loc_data", 32'(loc_data), 0);
        checkOutput("reset abort_cnt", 32'(abort_cnt), 0);

        // sl held low through reset release: no frame may start
        rst = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(24'h02_1111, 24, rd, ob);
        checkOutput("unselected oe quiet", ob, 0);
        sl = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("no write without sl fall", wr_stb_cnt, 0);
        loc_addr = 4'd2;
        repeat (2) @(negedge clk);
        checkOutput("reg2 untouched", 32'(loc_data), 0);

        // Basic write, local read, SPI read-back
        spiWrite(7'h05, 16'hA5C3);
        checkOutput("one wr_stb", wr_stb_cnt, 1);
        loc_addr = 4'd5;
        repeat (2) @(negedge clk);
        checkOutput("loc_data reg5", 32'(loc_data), 32'hA5C3);
        spiRead(7'h05);

        // Out-of-range write is dropped, out-of-range read returns zero
        spiWrite(7'h20, 16'h1234);
        checkOutput("no wr_stb out of range", wr_stb_cnt, 1);
        spiRead(7'h20);
        spiRead(7'h7F);

        // Address boundaries and a few random transactions
        spiWrite(7'h00, 16'hFFFF);
        spiWrite(7'h0F, 16'h8001);
        spiRead(7'h0F);
        spiRead(7'h00);
        for (int i = 0; i < 3; i++) begin
            ra   = 7'($urandom_range(0, 15));
            rdat = 16'($urandom);
            spiWrite(ra, rdat);
            spiRead(ra);
        end

        // Commit while the local port watches the same address
        loc_addr = 4'd9;
        repeat (2) @(negedge clk);
        spiWrite(7'h09, 16'h5A5A);
        spiWrite(7'h09, 16'hC0DE);

        // Abort after 12 bits of a write to address 3
        spiWrite(7'h03, 16'h3C3C);
        wr_stb_cnt = 0;
        sl = 1'b0;
        applyStimulus({1'b0, 7'h03, 16'hDEAD}, 12, rd, ob);
        sl = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort no wr_stb", wr_stb_cnt, 0);
        loc_addr = 4'd3;
        repeat (2) @(negedge clk);
        checkOutput("abort reg3 unchanged", 32'(loc_data), 32'h3C3C);
        checkOutput("abort_cnt after one abort", 32'(abort_cnt), CNT_EN ? 1 : 0);

        // Reset in the middle of a read releases the pin at once
        sl = 1'b0;
        applyStimulus({1'b1, 7'h03, 16'h0000}, 12, rd, ob);
        checkOutput("partial read oe window", ob, 0);
        checkOutput("oe driven mid-read", 32'(sdio_oe), 1);
        #3 rst = 1'b1;
        #1 checkOutput("oe released by rst", 32'(sdio_oe), 0);
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        sl  = 1'b1;
        sck = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_cnt cleared by rst", 32'(abort_cnt), 0);
        loc_addr = 4'd1;
        repeat (2) @(negedge clk);
        spiWrite(7'h01, 16'hBEEF);
        checkOutput("loc_data reg1", 32'(loc_data), 32'hBEEF);
        spiRead(7'h01);

        // Abort counter saturation
        for (int i = 0; i < 260; i++) begin
            sl = 1'b0;
            applyStimulus(24'h06_0000, 2, rd, ob);
            sl = 1'b1;
            repeat (4) @(negedge clk);
            if (i == 253) checkOutput("abort_cnt at 254", 32'(abort_cnt), CNT_EN ? 32'hFE : 0);
        end
        checkOutput("abort_cnt saturated", 32'(abort_cnt), CNT_EN ? 32'hFF : 0);
        checkOutput("write queue drained", exp_wr_q.size(), 0);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/bos_spi_slave.md
BOS_SPI_SLAVE -- requirements
Module: bos_spi_slave

Interface
REQ-001 Parameter: ADDR_W, 4, number of implemented register-address bits; the register file holds 2^ADDR_W x 16-bit registers.
REQ-002 Parameter: SCK_DIV_MIN, 8, minimum ratio of clk to sck frequency that the block is guaranteed to follow.
REQ-003 Port: clk  in  1  system clock; one clock domain only.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: sl  in  1  SPI chip select, active-low.
REQ-006 Port: sck  in  1  SPI clock, CPOL=1, CPHA=0.
REQ-007 Port: sdio_i  in  1  sampled value of the bidirectional data pin.
REQ-008 Port: sdio_o  out  1  data driven on the pin during the read phase.
REQ-009 Port: sdio_oe  out  1  pin drive enable; the tristate buffer is built at the instantiation site.
REQ-010 Port: loc_addr  in  ADDR_W  local read address.
REQ-011 Port: loc_data  out  16  local read data, registered.
REQ-012 Port: wr_stb  out  1  one-clk pulse for each committed SPI write.
REQ-013 Port: wr_addr  out  7  address of the last committed write.
REQ-014 Port: wr_data  out  16  data of the last committed write.
REQ-015 Port: abort_cnt  out  8  count of aborted frames (see Configuration).

Function
REQ-016 Synchronisation: sl, sck and sdio_i each pass through 2-FF synchronisers; sck edges come from a third delay stage, so pin-to-edge-detect latency is 3 clk.
REQ-017 Sampling: sdio sampled on sck falling edge; slave output updated on sck rising edge; frame is 24 bits, MSB first.
REQ-018 Frame format: bit23 = R/W (1 = read); bits22:16 = addr[6:0]; bits15:0 = data.
REQ-019 FSM states: IDLE, CMD, WR, RD, DONE.
REQ-020 IDLE->CMD on synced sl falling edge; bit counter cleared.
REQ-021 CMD->WR or CMD->RD after 8th sampled bit, per R/W.
REQ-022 RD: shift register loaded with reg[addr] at the 8th falling edge; sdio_oe asserts and sdio_o = data[15] at the next rising edge; each later rising edge shifts out the next bit.
REQ-023 WR: after the 24th sampled bit, write reg[addr] <= data; wr_stb pulses 1 clk later with wr_addr/wr_data valid; state goes to DONE.
REQ-024 RD ends in DONE after the 24th falling edge; sdio_oe deasserts at the following rising edge or on sl high, whichever comes first.
REQ-025 DONE: further sck edges ignored, sdio_oe held 0; DONE->IDLE on synced sl high.
REQ-026 Abort: synced sl high in CMD/WR/RD -> IDLE within 1 clk, no write, sdio_oe = 0 the same clk.
REQ-027 Out of range (addr[6:ADDR_W] != 0): write ignored, no wr_stb; read returns 16'h0000.
REQ-028 Local read: loc_data <= reg[loc_addr] each clk (1-clk latency); if an SPI write to the same address commits in the same clk, loc_data shows the old value and the new value one clk later.
REQ-029 sl low at reset release: FSM stays in IDLE until a fresh sl falling edge is seen.

Reset
REQ-030 On rst: all registers 16'h0000; FSM IDLE; sdio_oe = 0; sdio_o = 0; wr_stb = 0; wr_addr = 0; wr_data = 0; loc_data = 0; abort_cnt = 0; synchronisers set to idle levels (sl = 1, sck = 1).
REQ-031 rst mid-frame: the frame is discarded and the pin is released immediately (asynchronously).

Configuration
REQ-032 Macro BOS_SPI_SLAVE_ABORT_CNT_EN defined: abort_cnt increments by 1 per REQ-026 abort, saturates at 8'hFF, and is cleared only by rst.
REQ-033 Macro BOS_SPI_SLAVE_ABORT_CNT_EN undefined: abort_cnt is tied to 8'h00 and no counter logic is built.

Verification
REQ-034 Write 24'h05_A5C3 (R/W = 0, addr 5), then loc_addr = 5 -> one wr_stb, wr_addr = 5, wr_data = 16'hA5C3, loc_data = 16'hA5C3.
REQ-035 Read frame 24'h85_xxxx after REQ-034 -> master samples 16'hA5C3; sdio_oe high only between the 8th rising edge and frame end.
REQ-036 Write addr 7'h20 data 16'h1234 (ADDR_W = 4), then read addr 7'h20 -> no wr_stb; read returns 16'h0000.
REQ-037 sl raised after 12 bits of a write to addr 3 -> reg[3] unchanged; no wr_stb; abort_cnt = 1 with macro, 0 without.
REQ-038 rst asserted during the RD phase -> sdio_oe = 0 immediately; a following full write frame to addr 1 data 16'hBEEF completes normally.
REQ-039 Stress: 255+ aborts with macro defined -> abort_cnt = 8'hFF; run all scenarios at clk/sck = 8.
